// File: rtl/rename_unit_mw.sv
// rename_unit_mw -- multi-wide register rename unit.
//
// Renames up to RN_WIDTH instructions per cycle. An earlier slot in the same
// group that writes a destination forwards its new mapping to later slots.
// Commits up to CM_WIDTH lanes into the commit map table (CMT) and returns
// old mappings to the free list. Rolls back up to RB_WIDTH lanes per cycle.
// 'recover' restores the whole RAT from the CMT in a single cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rn_valid/rn_alloc        per-slot valid and destination-write flags
//   rn_ars1/rn_ars2/rn_ard   per-slot architectural sources and destination
//   rn_ready                 the group may fire this cycle
//   rn_prs1/rn_prs2          renamed sources
//   rn_prd_new/rn_prd_old    new and previous destination mapping
//   dq_preg/dq_ready         dispatch readiness queries, 2 per slot
//   wb_valid/wb_preg         writeback ports; these set ready bits
//   cm_en/cm_ard/cm_prd_*    commit lanes driven by the ROB
//   rb_en/rb_ard/rb_prd_*    rollback lanes, lane 0 youngest
//   recover                  full flush; RAT restored from the CMT
//   free_count               number of free physical registers

// Checks the free-count bound and the pointer invariant.
module rename_unit_mw_chk #(
  parameter int FL_DEPTH = 32,
  parameter int CW       = 6,
  parameter int FPW      = 5
) (
  input logic          clk,
  input logic          rst,
  input logic [CW:0]   count_sum,
  input logic [FPW-1:0] tail,
  input logic [FPW-1:0] cmt_head
);
  // The free count must never exceed the depth of the free list.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst)
    count_sum <= (CW+1)'(FL_DEPTH));

  // The commit tail and the CMT head always move together.
  a_ptr_invariant : assert property (@(posedge clk) disable iff (!rst)
    tail == cmt_head);
endmodule

module rename_unit_mw #(
  parameter int NUM_AREG = 64,
  parameter int NUM_PREG = 96,
  parameter int RN_WIDTH = 2,
  parameter int CM_WIDTH = 2,
  parameter int RB_WIDTH = 2,
  parameter int NUM_WB   = 2,
  localparam int AW       = $clog2(NUM_AREG),
  localparam int PW       = $clog2(NUM_PREG),
  localparam int FL_DEPTH = NUM_PREG - NUM_AREG,
  localparam int FPW      = $clog2(FL_DEPTH),
  localparam int CW       = $clog2(FL_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RN_WIDTH-1:0]        rn_valid,
  input  logic [RN_WIDTH-1:0]        rn_alloc,
  input  logic [RN_WIDTH*AW-1:0]     rn_ars1,
  input  logic [RN_WIDTH*AW-1:0]     rn_ars2,
  input  logic [RN_WIDTH*AW-1:0]     rn_ard,
  output logic                       rn_ready,
  output logic [RN_WIDTH*PW-1:0]     rn_prs1,
  output logic [RN_WIDTH*PW-1:0]     rn_prs2,
  output logic [RN_WIDTH*PW-1:0]     rn_prd_new,
  output logic [RN_WIDTH*PW-1:0]     rn_prd_old,
  input  logic [2*RN_WIDTH*PW-1:0]   dq_preg,
  output logic [2*RN_WIDTH-1:0]      dq_ready,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*PW-1:0]       wb_preg,
  input  logic [CM_WIDTH-1:0]        cm_en,
  input  logic [CM_WIDTH*AW-1:0]     cm_ard,
  input  logic [CM_WIDTH*PW-1:0]     cm_prd_new,
  input  logic [CM_WIDTH*PW-1:0]     cm_prd_old,
  input  logic [RB_WIDTH-1:0]        rb_en,
  input  logic [RB_WIDTH*AW-1:0]     rb_ard,
  input  logic [RB_WIDTH*PW-1:0]     rb_prd_new,
  input  logic [RB_WIDTH*PW-1:0]     rb_prd_old,
  input  logic                       recover,
  output logic [CW-1:0]              free_count
);

  logic [PW-1:0]       rat_r [NUM_AREG];
  logic [PW-1:0]       cmt_r [NUM_AREG];
  logic [PW-1:0]       fl_r  [FL_DEPTH];
  logic [NUM_PREG-1:0] ready_r;
  logic [FPW-1:0]      head_r;
  logic [FPW-1:0]      tail_r;
  logic [FPW-1:0]      cmt_head_r;
  logic [CW-1:0]       count_r;

  logic [PW-1:0]       new_s  [RN_WIDTH];
  logic [PW-1:0]       prs1_s [RN_WIDTH];
  logic [PW-1:0]       prs2_s [RN_WIDTH];
  logic [PW-1:0]       old_s  [RN_WIDTH];
  logic [CW-1:0]       alloc_n_s;
  logic [CW-1:0]       cm_cnt_s;
  logic [CW-1:0]       rb_cnt_s;
  logic [FPW-1:0]      cm_slot_s [CM_WIDTH];
  logic                fire_s;
  logic                rb_act_s;
  logic [CW:0]         count_sum_s;
  logic [NUM_PREG-1:0] ready_nxt_s;

  // Free-list pointer advance, wrapping modulo FL_DEPTH.
  function automatic logic [FPW-1:0] ptr_add(input logic [FPW-1:0] p, input logic [CW-1:0] n);
    logic [CW:0] s;
    s = {{(CW+1-FPW){1'b0}}, p} + {1'b0, n};
    if (s >= (CW+1)'(FL_DEPTH)) begin
      s = s - (CW+1)'(FL_DEPTH);
    end else begin
      s = s;
    end
    return s[FPW-1:0];
  endfunction

  // Free-list pointer step back, wrapping modulo FL_DEPTH.
  function automatic logic [FPW-1:0] ptr_sub(input logic [FPW-1:0] p, input logic [CW-1:0] n);
    logic [CW:0] s;
    s = {{(CW+1-FPW){1'b0}}, p} + (CW+1)'(FL_DEPTH) - {1'b0, n};
    if (s >= (CW+1)'(FL_DEPTH)) begin
      s = s - (CW+1)'(FL_DEPTH);
    end else begin
      s = s;
    end
    return s[FPW-1:0];
  endfunction

  // RAT lookup, free-list allocation and intra-group bypass.
  always_comb begin
    alloc_n_s  = '0;
    rn_prs1    = '0;
    rn_prs2    = '0;
    rn_prd_new = '0;
    rn_prd_old = '0;
    for (int i = 0; i < RN_WIDTH; i++) begin
      new_s[i]  = '0;
      prs1_s[i] = rat_r[rn_ars1[i*AW +: AW]];
      prs2_s[i] = rat_r[rn_ars2[i*AW +: AW]];
      old_s[i]  = rat_r[rn_ard[i*AW +: AW]];
    end
    for (int i = 0; i < RN_WIDTH; i++) begin
      // The n-th allocating slot takes the n-th entry past head.
      if (rn_valid[i] && rn_alloc[i]) begin
        new_s[i]  = fl_r[ptr_add(head_r, alloc_n_s)];
        alloc_n_s = alloc_n_s + CW'(1);
      end else begin
        new_s[i]  = '0;
      end
      // Ascending k: the youngest earlier writer of a register wins.
      for (int k = 0; k < RN_WIDTH; k++) begin
        if (k < i && rn_valid[k] && rn_alloc[k]) begin
          prs1_s[i] = (rn_ard[k*AW +: AW] == rn_ars1[i*AW +: AW]) ? new_s[k] : prs1_s[i];
          prs2_s[i] = (rn_ard[k*AW +: AW] == rn_ars2[i*AW +: AW]) ? new_s[k] : prs2_s[i];
          old_s[i]  = (rn_ard[k*AW +: AW] == rn_ard[i*AW +: AW])  ? new_s[k] : old_s[i];
        end else begin
          prs1_s[i] = prs1_s[i];
        end
      end
      rn_prs1[i*PW +: PW]    = prs1_s[i];
      rn_prs2[i*PW +: PW]    = prs2_s[i];
      rn_prd_new[i*PW +: PW] = new_s[i];
      rn_prd_old[i*PW +: PW] = old_s[i];
    end
  end

  // Handshake, lane counts and the next free count.
  always_comb begin
    rn_ready = (count_r >= alloc_n_s) && !recover && !(|rb_en);
    fire_s   = rn_ready && (|rn_valid);
    rb_act_s = (|rb_en) && !recover;
    cm_cnt_s = '0;
    rb_cnt_s = '0;
    for (int m = 0; m < CM_WIDTH; m++) begin
      cm_slot_s[m] = ptr_add(tail_r, cm_cnt_s);
      cm_cnt_s     = cm_cnt_s + (cm_en[m] ? CW'(1) : CW'(0));
    end
    // A rollback lane with prd_new == 0 never allocated, so it returns nothing.
    for (int m = 0; m < RB_WIDTH; m++) begin
      rb_cnt_s = rb_cnt_s + ((rb_en[m] && (rb_prd_new[m*PW +: PW] != '0)) ? CW'(1) : CW'(0));
    end
    if (recover) begin
      count_sum_s = (CW+1)'(FL_DEPTH);
    end else begin
      count_sum_s = {1'b0, count_r} + {1'b0, cm_cnt_s}
                  + (rb_act_s ? {1'b0, rb_cnt_s} : (CW+1)'(0))
                  - (fire_s ? {1'b0, alloc_n_s} : (CW+1)'(0));
    end
  end

  // Next ready map: writebacks and rollbacks set, a firing group clears last.
  always_comb begin
    ready_nxt_s = ready_r;
    for (int w = 0; w < NUM_WB; w++) begin
      ready_nxt_s[wb_preg[w*PW +: PW]] = ready_nxt_s[wb_preg[w*PW +: PW]] | wb_valid[w];
    end
    for (int m = 0; m < RB_WIDTH; m++) begin
      ready_nxt_s[rb_prd_new[m*PW +: PW]] = ready_nxt_s[rb_prd_new[m*PW +: PW]]
                                          | (rb_act_s & rb_en[m]);
    end
    for (int i = 0; i < RN_WIDTH; i++) begin
      ready_nxt_s[new_s[i]] = ready_nxt_s[new_s[i]] & ~(fire_s & rn_valid[i] & rn_alloc[i]);
    end
    if (recover) begin
      ready_nxt_s = '1;
    end else begin
      ready_nxt_s = ready_nxt_s;
    end
  end

  // Dispatch readiness with same-cycle writeback bypass; preg 0 is always ready.
  always_comb begin
    dq_ready = '0;
    for (int q = 0; q < 2*RN_WIDTH; q++) begin
      dq_ready[q] = ready_r[dq_preg[q*PW +: PW]] | (dq_preg[q*PW +: PW] == '0);
      for (int w = 0; w < NUM_WB; w++) begin
        dq_ready[q] = dq_ready[q] | (wb_valid[w] & (wb_preg[w*PW +: PW] == dq_preg[q*PW +: PW]));
      end
    end
  end

  // State update: commit every cycle, then recover > rollback > rename.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        rat_r[i] <= PW'(i);
        cmt_r[i] <= PW'(i);
      end
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_r[i] <= PW'(NUM_AREG + i);
      end
      ready_r    <= '1;
      head_r     <= '0;
      tail_r     <= '0;
      cmt_head_r <= '0;
      count_r    <= CW'(FL_DEPTH);
    end else begin
      for (int m = 0; m < CM_WIDTH; m++) begin
        if (cm_en[m]) begin
          fl_r[cm_slot_s[m]]          <= cm_prd_old[m*PW +: PW];
          cmt_r[cm_ard[m*AW +: AW]]   <= cm_prd_new[m*PW +: PW];
        end else begin
          fl_r[cm_slot_s[m]]          <= fl_r[cm_slot_s[m]];
        end
      end
      tail_r     <= ptr_add(tail_r, cm_cnt_s);
      cmt_head_r <= ptr_add(cmt_head_r, cm_cnt_s);
      count_r    <= count_sum_s[CW-1:0];
      ready_r    <= ready_nxt_s;
      if (recover) begin
        // Later writes win, so this cycle's commits land on top of the CMT copy.
        for (int i = 0; i < NUM_AREG; i++) begin
          rat_r[i] <= cmt_r[i];
        end
        for (int m = 0; m < CM_WIDTH; m++) begin
          if (cm_en[m]) begin
            rat_r[cm_ard[m*AW +: AW]] <= cm_prd_new[m*PW +: PW];
          end else begin
            rat_r[cm_ard[m*AW +: AW]] <= rat_r[cm_ard[m*AW +: AW]];
          end
        end
        head_r <= ptr_add(cmt_head_r, cm_cnt_s);
      end else if (rb_act_s) begin
        // Ascending lanes: the oldest lane's restore is the one that sticks.
        for (int m = 0; m < RB_WIDTH; m++) begin
          if (rb_en[m] && (rb_prd_new[m*PW +: PW] != '0)) begin
            rat_r[rb_ard[m*AW +: AW]] <= rb_prd_old[m*PW +: PW];
          end else begin
            rat_r[rb_ard[m*AW +: AW]] <= rat_r[rb_ard[m*AW +: AW]];
          end
        end
        head_r <= ptr_sub(head_r, rb_cnt_s);
      end else if (fire_s) begin
        for (int i = 0; i < RN_WIDTH; i++) begin
          if (rn_valid[i] && rn_alloc[i]) begin
            rat_r[rn_ard[i*AW +: AW]] <= new_s[i];
          end else begin
            rat_r[rn_ard[i*AW +: AW]] <= rat_r[rn_ard[i*AW +: AW]];
          end
        end
        head_r <= ptr_add(head_r, alloc_n_s);
      end else begin
        head_r <= head_r;
      end
    end
  end

  assign free_count = count_r;

  rename_unit_mw_chk #(
    .FL_DEPTH (FL_DEPTH),
    .CW       (CW),
    .FPW      (FPW)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .count_sum (count_sum_s),
    .tail      (tail_r),
    .cmt_head  (cmt_head_r)
  );

endmodule

// File: tb/tb_rename_unit_mw.sv
module tb_rename_unit_mw;
  localparam int AW  = 6;
  localparam int PW  = 7;
  localparam int RNW = 2;
  localparam int CMW = 2;
  localparam int RBW = 2;
  localparam int NWB = 2;
  localparam int CW  = 6;

  logic               clk;
  logic               rst;
  logic [RNW-1:0]     rn_valid, rn_alloc;
  logic [RNW*AW-1:0]  rn_ars1, rn_ars2, rn_ard;
  logic               rn_ready;
  logic [RNW*PW-1:0]  rn_prs1, rn_prs2, rn_prd_new, rn_prd_old;
  logic [2*RNW*PW-1:0] dq_preg;
  logic [2*RNW-1:0]   dq_ready;
  logic [NWB-1:0]     wb_valid;
  logic [NWB*PW-1:0]  wb_preg;
  logic [CMW-1:0]     cm_en;
  logic [CMW*AW-1:0]  cm_ard;
  logic [CMW*PW-1:0]  cm_prd_new, cm_prd_old;
  logic [RBW-1:0]     rb_en;
  logic [RBW*AW-1:0]  rb_ard;
  logic [RBW*PW-1:0]  rb_prd_new, rb_prd_old;
  logic               recover;
  logic [CW-1:0]      free_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  rename_unit_mw dut (
    .clk(clk), .rst(rst),
    .rn_valid(rn_valid), .rn_alloc(rn_alloc),
    .rn_ars1(rn_ars1), .rn_ars2(rn_ars2), .rn_ard(rn_ard),
    .rn_ready(rn_ready),
    .rn_prs1(rn_prs1), .rn_prs2(rn_prs2),
    .rn_prd_new(rn_prd_new), .rn_prd_old(rn_prd_old),
    .dq_preg(dq_preg), .dq_ready(dq_ready),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .cm_en(cm_en), .cm_ard(cm_ard), .cm_prd_new(cm_prd_new), .cm_prd_old(cm_prd_old),
    .rb_en(rb_en), .rb_ard(rb_ard), .rb_prd_new(rb_prd_new), .rb_prd_old(rb_prd_old),
    .recover(recover), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check_val({tag, "_no_expectation"}, 32'd1, 32'd0);
    end else begin
      check_val(tag, obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [31:0] o_new(input int i);  return 32'(rn_prd_new[i*PW +: PW]); endfunction
  function automatic logic [31:0] o_old(input int i);  return 32'(rn_prd_old[i*PW +: PW]); endfunction
  function automatic logic [31:0] o_prs1(input int i); return 32'(rn_prs1[i*PW +: PW]);    endfunction
  function automatic logic [31:0] o_prs2(input int i); return 32'(rn_prs2[i*PW +: PW]);    endfunction
  function automatic logic [31:0] o_dq(input int q);   return 32'(dq_ready[q]);            endfunction

  task automatic idle();
    rn_valid = '0; rn_alloc = '0; rn_ars1 = '0; rn_ars2 = '0; rn_ard = '0;
    dq_preg = '0; wb_valid = '0; wb_preg = '0;
    cm_en = '0; cm_ard = '0; cm_prd_new = '0; cm_prd_old = '0;
    rb_en = '0; rb_ard = '0; rb_prd_new = '0; rb_prd_old = '0;
    recover = 1'b0;
  endtask

  task automatic slot(input int i, input logic v, input logic a,
                      input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] d);
    rn_valid[i] = v; rn_alloc[i] = a;
    rn_ars1[i*AW +: AW] = s1; rn_ars2[i*AW +: AW] = s2; rn_ard[i*AW +: AW] = d;
  endtask

  task automatic query(input int q, input logic [PW-1:0] p);
    dq_preg[q*PW +: PW] = p;
  endtask

  task automatic wb(input int w, input logic [PW-1:0] p);
    wb_valid[w] = 1'b1; wb_preg[w*PW +: PW] = p;
  endtask

  task automatic cm(input int l, input logic [AW-1:0] d, input logic [PW-1:0] pn, input logic [PW-1:0] po);
    cm_en[l] = 1'b1; cm_ard[l*AW +: AW] = d; cm_prd_new[l*PW +: PW] = pn; cm_prd_old[l*PW +: PW] = po;
  endtask

  task automatic rb(input int l, input logic [AW-1:0] d, input logic [PW-1:0] pn, input logic [PW-1:0] po);
    rb_en[l] = 1'b1; rb_ard[l*AW +: AW] = d; rb_prd_new[l*PW +: PW] = pn; rb_prd_old[l*PW +: PW] = po;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    #7;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    query(0, 7'd0); query(1, 7'd95);
    push(32'd32); push(32'd1); push(32'd1); push(32'd1);
    #3;
    chk("rst_free", 32'(free_count)); chk("rst_ready", 32'(rn_ready));
    chk("dq_preg0", o_dq(0)); chk("rst_dq95", o_dq(1));
    tick();

    // Basic two-wide rename
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd5); slot(1, 1'b1, 1'b1, 6'd0, 6'd0, 6'd6); query(0, 7'd64);
    push(32'd64); push(32'd65); push(32'd5); push(32'd6); push(32'd1); push(32'd1);
    #3;
    chk("a_new0", o_new(0)); chk("a_new1", o_new(1)); chk("a_old0", o_old(0)); chk("a_old1", o_old(1));
    chk("a_ready", 32'(rn_ready)); chk("a_dq64_pre", o_dq(0));
    tick();
    query(0, 7'd64); query(1, 7'd65);
    push(32'd30); push(32'd0); push(32'd0);
    #3;
    chk("a_free", 32'(free_count)); chk("a_dq64", o_dq(0)); chk("a_dq65", o_dq(1));
    tick();

    // Intra-group bypass (reset mid-operation first)
    do_reset();
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd3); slot(1, 1'b1, 1'b1, 6'd3, 6'd3, 6'd3);
    push(32'd3); push(32'd64); push(32'd64); push(32'd64); push(32'd65);
    #3;
    chk("b_old0", o_old(0)); chk("b_prs1_1", o_prs1(1)); chk("b_prs2_1", o_prs2(1));
    chk("b_old1", o_old(1)); chk("b_new1", o_new(1));
    tick();
    slot(0, 1'b0, 1'b0, 6'd3, 6'd5, 6'd0);
    push(32'd65); push(32'd5); push(32'd30);
    #3;
    chk("b_rat3", o_prs1(0)); chk("b_rat5", o_prs2(0)); chk("b_free", 32'(free_count));
    tick();

    // Free-list exhaustion
    do_reset();
    for (int g = 0; g < 16; g++) begin
      slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd10); slot(1, 1'b1, 1'b1, 6'd0, 6'd0, 6'd11);
      if (g == 15) begin
        push(32'd94); push(32'd95);
        #3;
        chk("c_last_new0", o_new(0)); chk("c_last_new1", o_new(1));
      end else begin
        #3;
      end
      tick();
    end
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd12);
    push(32'd0); push(32'd0);
    #3;
    chk("c_free_empty", 32'(free_count)); chk("c_ready_alloc", 32'(rn_ready));
    tick();
    slot(0, 1'b1, 1'b0, 6'd1, 6'd2, 6'd12); slot(1, 1'b1, 1'b0, 6'd3, 6'd4, 6'd13);
    push(32'd1); push(32'd0); push(32'd0);
    #3;
    chk("c_ready_noalloc", 32'(rn_ready)); chk("c_noalloc_new0", o_new(0)); chk("c_noalloc_new1", o_new(1));
    tick();
    cm(0, 6'd10, 7'd94, 7'd3);
    push(32'd0);
    #3;
    chk("c_free_pre_cm", 32'(free_count));
    tick();
    slot(0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0); slot(1, 1'b1, 1'b1, 6'd0, 6'd0, 6'd12);
    push(32'd1); push(32'd1); push(32'd3);
    #3;
    chk("c_free_cm", 32'(free_count)); chk("c_ready_one", 32'(rn_ready)); chk("c_new_reuse", o_new(1));
    tick();
    push(32'd0);
    #3;
    chk("c_free_after", 32'(free_count));
    tick();

    // Rollback
    do_reset();
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd7);
    tick();
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd7);
    push(32'd65); push(32'd64);
    #3;
    chk("d_new", o_new(0)); chk("d_old", o_old(0));
    tick();
    rb(0, 6'd7, 7'd65, 7'd64); rb(1, 6'd7, 7'd64, 7'd7);
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd8); query(0, 7'd64);
    push(32'd0); push(32'd0); push(32'd30);
    #3;
    chk("d_ready_rb", 32'(rn_ready)); chk("d_dq64_pre", o_dq(0)); chk("d_free_pre", 32'(free_count));
    tick();
    slot(0, 1'b1, 1'b1, 6'd7, 6'd0, 6'd8); query(0, 7'd64); query(1, 7'd65);
    push(32'd7); push(32'd64); push(32'd32); push(32'd1); push(32'd1);
    #3;
    chk("d_rat7", o_prs1(0)); chk("d_head_back", o_new(0)); chk("d_free", 32'(free_count));
    chk("d_dq64", o_dq(0)); chk("d_dq65", o_dq(1));
    tick();

    // Recover with a same-cycle commit
    do_reset();
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd2); slot(1, 1'b1, 1'b1, 6'd0, 6'd0, 6'd4);
    tick();
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd9);
    push(32'd66);
    #3;
    chk("e_new_third", o_new(0));
    tick();
    recover = 1'b1; cm(0, 6'd2, 7'd64, 7'd2);
    push(32'd0); push(32'd29);
    #3;
    chk("e_ready_rec", 32'(rn_ready)); chk("e_free_pre", 32'(free_count));
    tick();
    slot(0, 1'b1, 1'b1, 6'd2, 6'd4, 6'd20); slot(1, 1'b1, 1'b1, 6'd9, 6'd0, 6'd21); query(0, 7'd66);
    push(32'd64); push(32'd4); push(32'd9); push(32'd65); push(32'd66); push(32'd32); push(32'd1);
    #3;
    chk("e_rat2", o_prs1(0)); chk("e_rat4", o_prs2(0)); chk("e_rat9", o_prs1(1));
    chk("e_head_new0", o_new(0)); chk("e_head_new1", o_new(1));
    chk("e_free", 32'(free_count)); chk("e_dq66", o_dq(0));
    tick();

    // Writeback bypass and clear-wins
    do_reset();
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd5); slot(1, 1'b1, 1'b1, 6'd0, 6'd0, 6'd6);
    tick();
    wb(0, 7'd65); wb(1, 7'd66); query(0, 7'd65); query(1, 7'd64);
    slot(0, 1'b1, 1'b1, 6'd0, 6'd0, 6'd7);
    push(32'd1); push(32'd0); push(32'd66);
    #3;
    chk("f_wb_bypass", o_dq(0)); chk("f_dq64_pre", o_dq(1)); chk("f_new", o_new(0));
    tick();
    query(0, 7'd66); query(1, 7'd65); query(2, 7'd64); query(3, 7'd0);
    push(32'd0); push(32'd1); push(32'd0); push(32'd1);
    #3;
    chk("f_clear_wins", o_dq(0)); chk("f_dq65", o_dq(1)); chk("f_dq64", o_dq(2)); chk("f_dq0", o_dq(3));
    tick();

    check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rename_unit_mw.md
Name: rename_unit_mw

Overview:
- Parametrised, multi-wide register rename unit. It is the next-generation replacement for the single-wide rename stage.
- Renames up to RN_WIDTH instructions per cycle, with intra-group dependency bypass and a free-count ready handshake.
- Retires up to CM_WIDTH instructions per cycle into the commit map table (CMT).
- Supports rollback of up to RB_WIDTH entries per cycle, plus a single-cycle flash recovery of the RAT from the CMT. Sits between decode and dispatch; the ROB drives the commit and rollback lanes.

Parameters:
NUM_AREG, 64, architectural registers (AW = $clog2(NUM_AREG))
NUM_PREG, 96, physical registers (PW = $clog2(NUM_PREG)); FL_DEPTH = NUM_PREG-NUM_AREG
RN_WIDTH, 2, rename slots per cycle
CM_WIDTH, 2, commit lanes per cycle
RB_WIDTH, 2, rollback lanes per cycle
NUM_WB, 2, writeback ports

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
rn_valid  in  RN_WIDTH  slot holds an instruction
rn_alloc  in  RN_WIDTH  slot writes a destination
rn_ars1/rn_ars2/rn_ard  in  RN_WIDTH*AW  arch sources/dest per slot
rn_ready  out  1  group may fire this cycle
rn_prs1/rn_prs2  out  RN_WIDTH*PW  renamed sources
rn_prd_new/rn_prd_old  out  RN_WIDTH*PW  new/previous dest mapping (new=0 if !rn_alloc)
dq_preg  in  2*RN_WIDTH*PW  dispatch ready-query pregs
dq_ready  out  2*RN_WIDTH  ready bit per query
wb_valid  in  NUM_WB  writeback strobe
wb_preg  in  NUM_WB*PW  writeback preg
cm_en  in  CM_WIDTH  lane commits an allocating instruction
cm_ard  in  CM_WIDTH*AW;  cm_prd_new/cm_prd_old  in  CM_WIDTH*PW
rb_en  in  RB_WIDTH  rollback lane valid (lane 0 youngest)
rb_ard  in  RB_WIDTH*AW;  rb_prd_new/rb_prd_old  in  RB_WIDTH*PW
recover  in  1  full flush; restore RAT from CMT
free_count  out  $clog2(FL_DEPTH+1)  free physical registers

Behaviour:
State and reset
- State: RAT/CMT (NUM_AREG x PW), ready map (NUM_PREG bits), circular free list (FL_DEPTH x PW), pointers head, tail, cmt_head, and count.
- Reset (async, rst=0): RAT[i]=CMT[i]=i; ready map all 1; freelist[i]=NUM_AREG+i; head=tail=cmt_head=0; count=FL_DEPTH; rn_ready=1.
- Preg 0 is never allocated, and dq_ready for preg 0 is always 1.

Rename (combinational lookup)
- Sources and old dest come from the RAT.
- Intra-group bypass: if an earlier slot k<i has valid&alloc and its ard equals slot i's ars1, ars2 or ard, slot i's output uses slot k's prd_new. When several earlier slots match, the highest such k wins.
- The n-th allocating valid slot (slot order) receives freelist[head+n].

Handshake
- N = popcount(rn_valid & rn_alloc).
- rn_ready = (count >= N) & !recover & !(|rb_en).
- The group fires all-or-nothing when rn_ready and any rn_valid are set. If rn_ready=0, no slot is renamed and the upstream stage holds.

On fire
- RAT[ard] <= prd_new for each allocating slot; the highest slot wins on equal ard.
- Ready bits of the new pregs are cleared; head += N; count -= N.

Commit (every cycle, independent of fire)
- Each cm_en lane, in lane order, writes freelist[tail+m] <= cm_prd_old and CMT[cm_ard] <= cm_prd_new. The higher lane wins on equal ard.
- tail and cmt_head advance by popcount(cm_en); count += that amount.
- Invariant: tail - cmt_head == FL_DEPTH (mod FL_DEPTH).

Rollback (|rb_en, !recover)
- Lanes with rb_prd_new != 0 restore RAT[rb_ard] <= rb_prd_old; on equal ard the oldest (highest) lane wins.
- Each such lane sets ready[rb_prd_new]=1. head and count step back by the number of such lanes.
- Rename is blocked that cycle.

Recover (highest priority)
- RAT <= CMT, including same-cycle commit writes.
- head <= cmt_head after this cycle's commits; count <= FL_DEPTH; ready map all 1.
- Rollback and rename are ignored that cycle.

Ready map and writeback
- Writeback sets ready[wb_preg].
- dq_ready = ready[q] | any same-cycle wb_valid match on q.
- If set and clear target the same preg in one cycle, the clear from the fire wins.

Counter rules
- All pointers wrap modulo FL_DEPTH.
- count never exceeds FL_DEPTH; exceeding it is an assertion failure, with no saturation.
- Reset asserted mid-operation discards all in-flight state.

Test Plan:
- After reset: slots 0/1 rename ard=5 and ard=6 with alloc -> prd_new=64/65, prd_old=5/6, count 32->30, dq_ready(64)=0.
- Intra-group bypass: slot0 ard=3, slot1 ars1=3 and ard=3 -> slot1 prs1=64, prd_old=64; RAT[3]=65 next cycle.
- Free-list exhaustion: fire 16 two-wide groups -> count=0, rn_ready=0 for any alloc request; a non-alloc group still fires; one commit (prd_old=3) gives count=1, and a 1-alloc group then receives preg 3.
- Rollback: rename ard=7 to 64, then ard=7 to 65; rb lane0 (new 65, old 64) and lane1 (new 64, old 7) -> RAT[7]=7, head back by 2, ready[64]=ready[65]=1, rn_ready=0 that cycle.
- Recover after 3 renames and 1 commit (ard=2, new=64, old=2) -> RAT[2]=64, other RAT entries match the CMT, count=32, head=cmt_head=1.
- Writeback bypass: wb_valid with wb_preg=65 and dq_preg=65 in the same cycle -> dq_ready=1; simultaneous wb on preg 66 and fire allocating 66 -> ready[66]=0.
